instr_fetch_unit: RTL and testbench

- Sits directly upstream of the combined fetch/decode/execute stage.
- Drives a pipelined request/grant/valid instruction-memory port and buffers returned words in a small FIFO.
- Hands the stage one instruction plus its address per valid/ready handshake.
- A redirect input (jump/branch target) flushes the buffer and discards all in-flight responses.

---
 rtl/toothless_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/instr_fetch_unit.sv | 208 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toothless_pkg.sv
// ---------------------------------------------------------------------------
// toothless_pkg
// Shared types and defaults for the instruction fetch unit.
//   fetch_state_e         : fetch state machine encoding (IDLE, RUN)
//   FETCH_FIFO_DEPTH      : default number of buffered instructions
//   FETCH_MAX_OUTSTANDING : default limit of granted-but-unanswered requests
//   FETCH_BOOT_ADDR       : default first fetch address after reset
// ---------------------------------------------------------------------------
package toothless_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam int          FETCH_FIFO_DEPTH      = 4;
  localparam int          FETCH_MAX_OUTSTANDING = 2;
  localparam logic [31:0] FETCH_BOOT_ADDR       = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with registered storage, synchronous flush and occupancy
// count. The head entry is always visible on head_data (no bypass path).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : empty the FIFO this cycle (wins over push/pop)
//   push         : write push_data at the tail
//   push_data    : data to write
//   pop          : remove the head entry
//   head_data    : current head entry
//   empty, full  : occupancy flags
//   count        : number of stored entries
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = mem[rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle, so the count never exceeds DEPTH.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetches sequential instruction words over a pipelined req/gnt/rvalid
// memory port, buffers them in a small FIFO and hands them to the
// fetch/decode/execute stage with a valid/ready handshake. A redirect
// flushes the buffer and discards every response still in flight.
// Optional feature macro: TOOTHLESS_FETCH_ERR_EN (adds mem_err_i and
// instr_err_o; an erroring response stops sequential fetch until redirect).
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   fetch_en_i                     : start / keep fetching
//   redirect_i, redirect_addr_i    : control transfer and its target
//   mem_req_o, mem_addr_o          : memory request and address
//   mem_gnt_i                      : request accepted this cycle
//   mem_rvalid_i, mem_rdata_i      : in-order memory response
//   instr_valid_o, instr_ready_i   : instruction handshake
//   instr_rdata_o, instr_addr_o    : head instruction and its address
//   busy_o                         : requests outstanding or buffer non-empty
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import toothless_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    INSTR_WIDTH     = 32,
  parameter int                    FIFO_DEPTH      = FETCH_FIFO_DEPTH,
  parameter int                    MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR       = ADDR_WIDTH'(FETCH_BOOT_ADDR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_i,
  output logic                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] mem_rdata_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  output logic                   busy_o
`ifdef TOOTHLESS_FETCH_ERR_EN
  ,
  input  logic                   mem_err_i,
  output logic                   instr_err_o
`endif
);

`ifdef TOOTHLESS_FETCH_ERR_EN
  localparam int ERR_W = 1;
`else
  localparam int ERR_W = 0;
`endif
  localparam int EW  = ADDR_WIDTH + INSTR_WIDTH + ERR_W;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [OCW-1:0]        outstanding;
  logic [OCW-1:0]        discard;
  logic                  aq_empty;
  logic                  aq_full;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [FCW-1:0]        fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [EW-1:0]         push_entry;
  logic [EW-1:0]         head_entry;
  logic                  grant;
  logic                  rsp_valid;
  logic                  keep_rsp;
  logic                  req_block;
  int                    space;

  // Targets are word aligned; masking (rather than slicing) keeps every
  // redirect address bit in use.
  assign redirect_target = redirect_addr_i & ~ADDR_WIDTH'(3);

  assign grant      = mem_req_o & mem_gnt_i;
  assign rsp_valid  = mem_rvalid_i & ~aq_empty;
  assign keep_rsp   = rsp_valid & (discard == '0) & ~redirect_i;
  assign mem_addr_o = fetch_addr;

  // Free buffer slots not yet promised to live in-flight responses.
  always_comb begin
    space = FIFO_DEPTH - int'(fifo_count) - int'(outstanding) + int'(discard);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and request. An ungranted request keeps RUN alive so that
  // mem_req_o stays stable until the memory accepts it.
  always_comb begin
    state_d   = state_q;
    mem_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_en_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mem_req_o = (space > 0) && !aq_full && !fifo_full && !req_block;
        if (!fetch_en_i && !(mem_req_o && !mem_gnt_i)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch address: redirect overrides the sequential increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr <= BOOT_ADDR;
    end else if (redirect_i) begin
      fetch_addr <= redirect_target;
    end else if (grant) begin
      fetch_addr <= fetch_addr + ADDR_WIDTH'(4);
    end
  end

  // Every response still owed at a redirect (including one granted in the
  // redirect cycle) belongs to the abandoned path and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard <= '0;
    end else if (redirect_i) begin
      discard <= outstanding + OCW'(grant) - OCW'(rsp_valid);
    end else if (rsp_valid && (discard != '0)) begin
      discard <= discard - OCW'(1);
    end
  end

`ifdef TOOTHLESS_FETCH_ERR_EN
  logic err_stop;

  // A faulting fetch halts sequential prefetch until the core redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_stop <= 1'b0;
    end else if (redirect_i) begin
      err_stop <= 1'b0;
    end else if (keep_rsp && mem_err_i) begin
      err_stop <= 1'b1;
    end
  end

  assign req_block   = err_stop;
  assign push_entry  = {mem_err_i, rsp_addr, mem_rdata_i};
  assign instr_err_o = head_entry[EW-1];
`else
  assign req_block  = 1'b0;
  assign push_entry = {rsp_addr, mem_rdata_i};
`endif

  // Address queue: one entry per granted request, popped by every response
  // (kept or discarded), so its occupancy is the outstanding count.
  fetch_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_addr_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (grant),
    .push_data (fetch_addr),
    .pop       (rsp_valid),
    .head_data (rsp_addr),
    .empty     (aq_empty),
    .full      (aq_full),
    .count     (outstanding)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (keep_rsp),
    .push_data (push_entry),
    .pop       (instr_valid_o & instr_ready_i),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign instr_valid_o = ~fifo_empty;
  assign instr_rdata_o = head_entry[INSTR_WIDTH-1:0];
  assign instr_addr_o  = head_entry[INSTR_WIDTH +: ADDR_WIDTH];
  assign busy_o        = ~aq_empty | ~fifo_empty;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with a transaction-level reference
// model (program-order address, in-flight response list, instruction queue)
// and a response memory returning rdata = addr ^ 32'hA5A5A5A5.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] PATTERN = 32'hA5A5_A5A5;
  localparam int          DEPTH   = 4;
  localparam int          MAXOUT  = 2;

  logic        clk;
  logic        rst_n;
  logic        fetch_en_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        busy_o;
  logic        mem_err_i;
  logic        instr_err_o;

  logic        gnt_allow;
  int          lat;
  logic        err_en;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [31:0] addr; logic stale; } flight_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic err; } entry_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  flight_t     inflight[$];
  entry_t      mfifo[$];
  mreq_t       mq[$];
  logic [31:0] exp_addr;
  logic        err_stop_m;
  logic        prev_stall;
  logic [31:0] prev_addr;
  logic        en_prev;
  logic        nxt_valid;
  logic [31:0] nxt_data;
  logic        nxt_err;
  int          cyc;
  int          num_grants;
  logic [31:0] last_gnt;

  assign mem_gnt_i = gnt_allow & mem_req_o;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en_i      (fetch_en_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_rdata_o   (instr_rdata_o),
    .instr_addr_o    (instr_addr_o),
    .busy_o          (busy_o)
`ifdef TOOTHLESS_FETCH_ERR_EN
    ,
    .mem_err_i       (mem_err_i),
    .instr_err_o     (instr_err_o)
`endif
  );

`ifndef TOOTHLESS_FETCH_ERR_EN
  assign instr_err_o = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic gnt, input int latency);
    fetch_en_i    = en;
    instr_ready_i = rdy;
    gnt_allow     = gnt;
    lat           = latency;
  endtask

  task automatic applyRedirect(input logic [31:0] target);
    redirect_i      = 1'b1;
    redirect_addr_i = target;
    tick(1);
    redirect_i      = 1'b0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    redirect_i = 1'b0;
    err_en     = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Memory: answers granted requests in order, lat cycles after the grant.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_err_i    = 1'b0;
    end else begin
      mem_rvalid_i = nxt_valid;
      mem_rdata_i  = nxt_data;
      mem_err_i    = nxt_err;
    end
  end

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    int          ns;
    int          space_m;
    logic        g, r, p, d;
    flight_t     f;
    mreq_t       m;
    cyc++;
    if (!rst_n) begin
      inflight.delete();
      mfifo.delete();
      mq.delete();
      exp_addr   = 32'h0;
      err_stop_m = 1'b0;
      prev_stall = 1'b0;
      en_prev    = 1'b0;
      nxt_valid  = 1'b0;
      nxt_err    = 1'b0;
    end else begin
      ns = 0;
      foreach (inflight[i]) if (!inflight[i].stale) ns++;
      space_m = DEPTH - mfifo.size() - ns;

      checkOutput("instr_valid", instr_valid_o, mfifo.size() != 0);
      if (mfifo.size() != 0) begin
        checkOutput("instr_addr", instr_addr_o, mfifo[0].addr);
        checkOutput("instr_rdata", instr_rdata_o, mfifo[0].data);
`ifdef TOOTHLESS_FETCH_ERR_EN
        checkOutput("instr_err", instr_err_o, mfifo[0].err);
`endif
      end
      checkOutput("busy", busy_o, (inflight.size() != 0) || (mfifo.size() != 0));
      checkOutput("mem_addr", mem_addr_o, exp_addr);
      if (mem_req_o) checkOutput("req_allowed", (space_m > 0) && (inflight.size() < MAXOUT), 1);
      if (prev_stall) begin
        checkOutput("req_hold", mem_req_o, 1);
        checkOutput("addr_hold", mem_addr_o, prev_addr);
      end
      if (fetch_en_i && en_prev && space_m > 0 && inflight.size() < MAXOUT && !err_stop_m)
        checkOutput("req_expected", mem_req_o, 1);
      if (!fetch_en_i && !en_prev && !prev_stall) checkOutput("req_idle", mem_req_o, 0);
      if (err_stop_m) checkOutput("req_after_err", mem_req_o, 0);

      g = mem_req_o && mem_gnt_i;
      r = mem_rvalid_i;
      p = instr_valid_o && instr_ready_i;
      d = redirect_i;

      if (p && mfifo.size() != 0) void'(mfifo.pop_front());
      if (r) begin
        checkOutput("rvalid_outstanding", inflight.size() != 0, 1);
        if (inflight.size() != 0) begin
          f = inflight.pop_front();
          if (!f.stale && !d) begin
            mfifo.push_back('{addr: f.addr, data: f.addr ^ PATTERN, err: err_en && (f.addr == err_addr)});
            if (err_en && (f.addr == err_addr)) err_stop_m = 1'b1;
          end
        end
      end
      if (g) begin
        inflight.push_back('{addr: mem_addr_o, stale: d});
        mq.push_back('{addr: mem_addr_o, due: cyc + lat});
        num_grants++;
        last_gnt = mem_addr_o;
      end
      if (d) begin
        mfifo.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        exp_addr   = {redirect_addr_i[31:2], 2'b00};
        err_stop_m = 1'b0;
      end else if (g) begin
        exp_addr = exp_addr + 32'd4;
      end
      checkOutput("fifo_overflow", mfifo.size() <= DEPTH, 1);
      checkOutput("outstanding_bound", inflight.size() <= MAXOUT, 1);

      prev_stall = mem_req_o && !mem_gnt_i && !d;
      prev_addr  = mem_addr_o;
      en_prev    = fetch_en_i;

      nxt_valid = 1'b0;
      nxt_err   = 1'b0;
      if (mq.size() != 0 && mq[0].due <= cyc + 1) begin
        m         = mq.pop_front();
        nxt_valid = 1'b1;
        nxt_data  = m.addr ^ PATTERN;
        nxt_err   = err_en && (m.addr == err_addr);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int g0;
    cyc             = 0;
    num_grants      = 0;
    last_gnt        = '0;
    nxt_valid       = 1'b0;
    nxt_data        = '0;
    nxt_err         = 1'b0;
    redirect_i      = 1'b0;
    redirect_addr_i = '0;
    err_en          = 1'b0;
    err_addr        = '0;
    rst_n           = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1);

    // Reset values and start-up latency.
    tick(2);
    checkOutput("rst_mem_req", mem_req_o, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
    checkOutput("rst_instr_valid", instr_valid_o, 0);
    checkOutput("rst_instr_rdata", instr_rdata_o, 32'h0);
    checkOutput("rst_instr_addr", instr_addr_o, 32'h0);
    checkOutput("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    tick(2);
    checkOutput("idle_no_req", mem_req_o, 0);
    fetch_en_i = 1'b1;
    n = 0;
    while (n < 10 && !instr_valid_o) begin
      tick(1);
      n++;
    end
    checkOutput("first_valid_latency", n, 3);
    checkOutput("first_addr", instr_addr_o, 32'h0);
    checkOutput("first_rdata", instr_rdata_o, 32'hA5A5_A5A5);
    tick(20);

    // Consumer stalled: buffer fills, then one pop frees one request.
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    tick(10);
    checkOutput("full_valid", instr_valid_o, 1);
    checkOutput("full_head_addr", instr_addr_o, 32'h0);
    checkOutput("full_no_req", mem_req_o, 0);
    checkOutput("full_busy", busy_o, 1);
    instr_ready_i = 1'b1;
    tick(1);
    instr_ready_i = 1'b0;
    checkOutput("refill_req", mem_req_o, 1);
    checkOutput("refill_addr", mem_addr_o, 32'h10);
    checkOutput("refill_head", instr_addr_o, 32'h4);
    g0 = num_grants;
    tick(6);
    checkOutput("refill_one_grant", num_grants - g0, 1);
    checkOutput("refill_then_stop", mem_req_o, 0);

    // Redirect with two responses in flight.
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 3);
    n = 0;
    while (n < 20 && inflight.size() != 2) begin
      tick(1);
      n++;
    end
    checkOutput("two_outstanding_reached", inflight.size(), 2);
    applyRedirect(32'h103);
    checkOutput("redir_addr", mem_addr_o, 32'h100);
    checkOutput("redir_valid_low", instr_valid_o, 0);
    n = 0;
    while (n < 30 && !instr_valid_o) begin
      tick(1);
      n++;
    end
    checkOutput("redir_first_addr", instr_addr_o, 32'h100);
    checkOutput("redir_first_rdata", instr_rdata_o, 32'hA5A5_A4A5);
    tick(10);

    // Grant withheld, redirect during the stall.
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_req", mem_req_o, 1);
      checkOutput("stall_addr", mem_addr_o, 32'h0);
      tick(1);
    end
    applyRedirect(32'h200);
    checkOutput("stall_redir_req", mem_req_o, 1);
    checkOutput("stall_redir_addr", mem_addr_o, 32'h200);
    gnt_allow = 1'b1;
    n = 0;
    while (n < 20 && !instr_valid_o) begin
      tick(1);
      n++;
    end
    checkOutput("stall_first_addr", instr_addr_o, 32'h200);
    tick(4);

    // Address wrap at the top of the address space.
    applyRedirect(32'hFFFF_FFFC);
    checkOutput("wrap_req", mem_req_o, 1);
    checkOutput("wrap_addr", mem_addr_o, 32'hFFFF_FFFC);
    tick(1);
    checkOutput("wrap_next_addr", mem_addr_o, 32'h0);
    tick(8);

    // Drain to idle, then reset in the middle of fetching.
    fetch_en_i = 1'b0;
    tick(10);
    checkOutput("drain_busy", busy_o, 0);
    fetch_en_i = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", mem_req_o, 0);
    checkOutput("midrst_valid", instr_valid_o, 0);
    checkOutput("midrst_busy", busy_o, 0);
    checkOutput("midrst_addr", mem_addr_o, 32'h0);
    fetch_en_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checkOutput("post_rst_idle", mem_req_o, 0);

`ifdef TOOTHLESS_FETCH_ERR_EN
    // Erroring response stops sequential fetch until redirect.
    applyReset();
    err_en   = 1'b1;
    err_addr = 32'h8;
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    n = 0;
    while (n < 20 && !(instr_valid_o && instr_addr_o == 32'h8)) begin
      tick(1);
      n++;
    end
    checkOutput("err_addr", instr_addr_o, 32'h8);
    checkOutput("err_flag", instr_err_o, 1);
    tick(6);
    checkOutput("err_no_req", mem_req_o, 0);
    checkOutput("err_last_grant", last_gnt, 32'hC);
    applyRedirect(32'h40);
    checkOutput("err_resume_req", mem_req_o, 1);
    checkOutput("err_resume_addr", mem_addr_o, 32'h40);
    err_en = 1'b0;
    tick(6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
